// File: rtl/alsu_req_arbiter.sv
// alsu_req_arbiter
//   Shares one ALSU between two requesters. A round-robin grant picks a command,
//   which is latched onto the ALSU input pins. After the ALSU pipeline latency the
//   ALSU result is captured and returned as a tagged response over valid/ready.
//   Only one transaction is ever in flight.
// Ports
//   clk, rst                 clock; synchronous active-low reset
//   req_valid/req_ready      per-requester command handshake (ready is one-hot or zero)
//   req_opcode/A/B/ctrl      packed {req1,req0} command fields
//   alsu_opcode/A/B/ctrl     held command driven to the ALSU
//   alsu_out/alsu_leds       ALSU result and invalid-op indication
//   rsp_valid/rsp_ready      response handshake
//   rsp_id/out/err           requester tag, captured result, captured error flag
//   busy                     transaction in progress
//   err_cnt                  saturating count of accepted error responses
module alsu_req_arbiter #(
  parameter int unsigned ALSU_LATENCY = 2,
  parameter int unsigned RESET_PRI    = 0,
  parameter int unsigned ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [5:0]           req_opcode,
  input  logic [5:0]           req_A,
  input  logic [5:0]           req_B,
  input  logic [13:0]          req_ctrl,
  output logic [2:0]           alsu_opcode,
  output logic signed [2:0]    alsu_A,
  output logic signed [2:0]    alsu_B,
  output logic [6:0]           alsu_ctrl,
  input  logic signed [5:0]    alsu_out,
  input  logic [15:0]          alsu_leds,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic signed [5:0]    rsp_out,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned CNT_W = $clog2(ALSU_LATENCY + 2);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALSU_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             pref;       // requester that wins the next tie
  logic             grant_sel;
  logic             take;
  logic             capture;
  logic             rsp_done;

  always_comb begin
    grant_sel = pref;
    if (req_valid == 2'b01) begin
      grant_sel = 1'b0;
    end else if (req_valid == 2'b10) begin
      grant_sel = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    take      = 1'b0;
    capture   = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          req_ready = grant_sel ? 2'b10 : 2'b01;
          take      = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // capture on the edge where the counter reaches zero
        if (wait_cnt == CNT_W'(1)) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      alsu_opcode <= '0;
      alsu_A      <= '0;
      alsu_B      <= '0;
      alsu_ctrl   <= '0;
      rsp_id      <= 1'b0;
      rsp_out     <= '0;
      rsp_err     <= 1'b0;
      err_cnt     <= '0;
      wait_cnt    <= '0;
      pref        <= 1'(RESET_PRI);
    end else begin
      if (take) begin
        alsu_opcode <= grant_sel ? req_opcode[5:3] : req_opcode[2:0];
        alsu_A      <= grant_sel ? req_A[5:3]      : req_A[2:0];
        alsu_B      <= grant_sel ? req_B[5:3]      : req_B[2:0];
        alsu_ctrl   <= grant_sel ? req_ctrl[13:7]  : req_ctrl[6:0];
        rsp_id      <= grant_sel;
        pref        <= ~grant_sel;
        wait_cnt    <= CNT_LOAD;
      end
      if (state == WAIT) begin
        wait_cnt <= wait_cnt - CNT_W'(1);
      end
      if (capture) begin
        rsp_out <= alsu_out;
        rsp_err <= |alsu_leds;
      end
      if (rsp_done && rsp_err && !(&err_cnt)) begin
        err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alsu_req_arbiter.sv
// tb_alsu_req_arbiter
//   Drives randomized and directed commands into alsu_req_arbiter, with a small
//   two-stage ALSU stand-in behind it, and compares every response, grant and
//   status output against a transaction-level reference model.
module tb_alsu_req_arbiter;

  localparam int unsigned ERR_W   = 3;
  localparam int unsigned ERR_MAX = (1 << ERR_W) - 1;
  localparam int unsigned PRI     = 0;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [5:0]           req_opcode;
  logic [5:0]           req_A;
  logic [5:0]           req_B;
  logic [13:0]          req_ctrl;
  logic [2:0]           alsu_opcode;
  logic signed [2:0]    alsu_A;
  logic signed [2:0]    alsu_B;
  logic [6:0]           alsu_ctrl;
  logic signed [5:0]    alsu_out = '0;
  logic [15:0]          alsu_leds = '0;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_id;
  logic signed [5:0]    rsp_out;
  logic                 rsp_err;
  logic                 busy;
  logic [ERR_W-1:0]     err_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // reference model state
  int          m_pref;
  int unsigned m_err;
  logic [2:0]  cmd_op [2];
  logic [2:0]  cmd_a  [2];
  logic [2:0]  cmd_b  [2];
  logic [6:0]  cmd_c  [2];

  alsu_req_arbiter #(
    .ALSU_LATENCY (2),
    .RESET_PRI    (PRI),
    .ERR_CNT_W    (ERR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_opcode  (req_opcode),
    .req_A       (req_A),
    .req_B       (req_B),
    .req_ctrl    (req_ctrl),
    .alsu_opcode (alsu_opcode),
    .alsu_A      (alsu_A),
    .alsu_B      (alsu_B),
    .alsu_ctrl   (alsu_ctrl),
    .alsu_out    (alsu_out),
    .alsu_leds   (alsu_leds),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_out     (rsp_out),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  // ALSU stand-in result: cin is ctrl[6]; opcodes 6/7 are invalid
  function automatic logic [5:0] alsu_f(input logic [2:0] op, input logic [2:0] a,
                                        input logic [2:0] b, input logic [6:0] c);
    int ia;
    int ib;
    int r;
    ia = int'($signed(a));
    ib = int'($signed(b));
    case (op)
      3'd0:    r = ia & ib;
      3'd1:    r = ia ^ ib;
      3'd2:    r = ia + ib + int'(c[6]);
      3'd3:    r = ia * ib;
      3'd4:    r = ia - ib;
      3'd5:    r = int'({a, b});
      default: r = 0;
    endcase
    return r[5:0];
  endfunction

  // two register stages: inputs registered, then result registered
  logic [2:0] s_op = '0;
  logic [2:0] s_a  = '0;
  logic [2:0] s_b  = '0;
  logic [6:0] s_c  = '0;
  always @(posedge clk) begin
    s_op      <= alsu_opcode;
    s_a       <= alsu_A;
    s_b       <= alsu_B;
    s_c       <= alsu_ctrl;
    alsu_out  <= alsu_f(s_op, s_a, s_b, s_c);
    alsu_leds <= (s_op >= 3'd6) ? 16'hFFFF : 16'h0000;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic scramble_reqs();
    req_valid  = 2'($urandom);
    req_opcode = 6'($urandom);
    req_A      = 6'($urandom);
    req_B      = 6'($urandom);
    req_ctrl   = 14'($urandom);
  endtask

  task automatic rand_cmds(input bit allow_bad);
    for (int i = 0; i < 2; i++) begin
      cmd_op[i] = allow_bad ? 3'($urandom) : 3'($urandom_range(0, 5));
      cmd_a[i]  = 3'($urandom);
      cmd_b[i]  = 3'($urandom);
      cmd_c[i]  = 7'($urandom);
    end
  endtask

  task automatic run_txn(input logic [1:0] vld, input int unsigned hold, input bit abort);
    int         g;
    logic [5:0] e_out;
    logic       e_err;
    req_valid  = vld;
    req_opcode = {cmd_op[1], cmd_op[0]};
    req_A      = {cmd_a[1], cmd_a[0]};
    req_B      = {cmd_b[1], cmd_b[0]};
    req_ctrl   = {cmd_c[1], cmd_c[0]};
    rsp_ready  = 1'b0;
    #1;
    if (vld == 2'b01)      g = 0;
    else if (vld == 2'b10) g = 1;
    else                   g = m_pref;
    chk("grant", {30'b0, req_ready}, (g == 1) ? 32'd2 : 32'd1);
    chk("busy_idle", {31'b0, busy}, 32'd0);
    e_out = alsu_f(cmd_op[g], cmd_a[g], cmd_b[g], cmd_c[g]);
    e_err = (cmd_op[g] >= 3'd6);
    tick();
    m_pref = 1 - g;
    for (int k = 1; k <= 3; k++) begin
      scramble_reqs();
      #1;
      chk("alsu_opcode", {29'b0, alsu_opcode}, {29'b0, cmd_op[g]});
      chk("alsu_A", {29'b0, $unsigned(alsu_A)}, {29'b0, cmd_a[g]});
      chk("alsu_B", {29'b0, $unsigned(alsu_B)}, {29'b0, cmd_b[g]});
      chk("alsu_ctrl", {25'b0, alsu_ctrl}, {25'b0, cmd_c[g]});
      chk("ready_wait", {30'b0, req_ready}, 32'd0);
      chk("busy_wait", {31'b0, busy}, 32'd1);
      chk("rsp_valid_wait", {31'b0, rsp_valid}, 32'd0);
      if (abort && k == 2) begin
        req_valid = 2'b00;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        m_pref = PRI;
        m_err  = 0;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_alsu", {20'b0, alsu_opcode, $unsigned(alsu_A), $unsigned(alsu_B)}, 32'd0);
        chk("rst_ctrl", {25'b0, alsu_ctrl}, 32'd0);
        chk("rst_rsp", {24'b0, rsp_id, rsp_err, $unsigned(rsp_out)}, 32'd0);
        chk("rst_err_cnt", {29'b0, err_cnt}, 32'd0);
        for (int j = 0; j < 6; j++) begin
          tick();
          chk("dropped_no_rsp", {31'b0, rsp_valid}, 32'd0);
          chk("dropped_idle", {31'b0, busy}, 32'd0);
        end
        return;
      end
      tick();
    end
    for (int unsigned h = 0; h <= hold; h++) begin
      scramble_reqs();
      #1;
      chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("rsp_id", {31'b0, rsp_id}, g);
      chk("rsp_out", {26'b0, $unsigned(rsp_out)}, {26'b0, e_out});
      chk("rsp_err", {31'b0, rsp_err}, {31'b0, e_err});
      chk("busy_resp", {31'b0, busy}, 32'd1);
      chk("ready_resp", {30'b0, req_ready}, 32'd0);
      chk("err_cnt_resp", {29'b0, err_cnt}, m_err);
      if (h == hold) rsp_ready = 1'b1;
      tick();
    end
    rsp_ready = 1'b0;
    req_valid = 2'b00;
    if (e_err && m_err < ERR_MAX) m_err++;
    #1;
    chk("busy_after", {31'b0, busy}, 32'd0);
    chk("rsp_valid_after", {31'b0, rsp_valid}, 32'd0);
    chk("err_cnt_after", {29'b0, err_cnt}, m_err);
  endtask

  initial begin
    rst        = 1'b0;
    req_valid  = '0;
    req_opcode = '0;
    req_A      = '0;
    req_B      = '0;
    req_ctrl   = '0;
    rsp_ready  = 1'b0;
    m_pref     = PRI;
    m_err      = 0;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_alsu", {20'b0, alsu_opcode, $unsigned(alsu_A), $unsigned(alsu_B)}, 32'd0);
    chk("reset_err_cnt", {29'b0, err_cnt}, 32'd0);
    chk("reset_ready", {30'b0, req_ready}, 32'd0);

    // both requesters valid back to back from reset: alternating grants
    for (int i = 0; i < 4; i++) begin
      rand_cmds(1'b0);
      run_txn(2'b11, 0, 1'b0);
    end

    // req0 ADD 3+2+cin -> 6
    rand_cmds(1'b0);
    cmd_op[0] = 3'd2; cmd_a[0] = 3'd3; cmd_b[0] = 3'd2; cmd_c[0] = 7'b1000000;
    run_txn(2'b01, 0, 1'b0);
    chk("add_result", 32'(alsu_f(3'd2, 3'd3, 3'd2, 7'b1000000)), 32'd6);

    // req1 invalid opcode 7 -> error, err_cnt 0 -> 1
    rand_cmds(1'b0);
    cmd_op[1] = 3'd7;
    run_txn(2'b10, 0, 1'b0);
    chk("err_cnt_first", {29'b0, err_cnt}, 32'd1);

    // consumer stalls five cycles
    rand_cmds(1'b0);
    run_txn(2'b11, 5, 1'b0);

    // req0 MULT -3*3 -> -9
    rand_cmds(1'b0);
    cmd_op[0] = 3'd3; cmd_a[0] = 3'b101; cmd_b[0] = 3'd3;
    run_txn(2'b01, 0, 1'b0);
    chk("mult_neg", {26'b0, $unsigned(rsp_out)}, 32'b110111);

    // randomized traffic with idle gaps and withdrawn requests
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        req_valid = 2'b00;
        #1;
        chk("ready_none", {30'b0, req_ready}, 32'd0);
        tick();
      end
      rand_cmds(1'b1);
      run_txn(2'($urandom_range(1, 3)), $urandom_range(0, 3), 1'b0);
    end

    // drive the error counter into saturation
    for (int i = 0; i < int'(ERR_MAX) + 2; i++) begin
      rand_cmds(1'b0);
      cmd_op[0] = 3'd7;
      cmd_op[1] = 3'd6;
      run_txn(2'($urandom_range(1, 3)), 0, 1'b0);
    end
    chk("err_cnt_sat", {29'b0, err_cnt}, ERR_MAX);

    // reset in the middle of WAIT drops the command
    rand_cmds(1'b0);
    run_txn(2'($urandom_range(1, 3)), 0, 1'b1);

    // tie after reset goes back to the reset priority
    rand_cmds(1'b0);
    run_txn(2'b11, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
